// File: rtl/pooling_engine.sv
// pooling_engine: sequential KxK average/max pooling over a latched IMG_SIZE x IMG_SIZE feature map
module pooling_engine #(
   parameter int DATA_W   = 16,
   parameter int IMG_SIZE = 5,
   parameter int K        = 2,
   parameter int OUT_SIZE = IMG_SIZE / K,
   localparam int IW      = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                start,
   input  logic                                mode,
   input  logic [IMG_SIZE*IMG_SIZE*DATA_W-1:0] image_in,
   output logic                                busy,
   output logic [DATA_W-1:0]                   pixel_out,
   output logic                                out_valid,
   output logic [IW-1:0]                       out_row,
   output logic [IW-1:0]                       out_col,
   output logic                                finish
);
   localparam int KW = $clog2(K);
   localparam int SH = 2 * KW;
   localparam int AW = DATA_W + SH;
   localparam int NB = IMG_SIZE * IMG_SIZE * DATA_W;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ACC  = 2'd1;
   localparam logic [1:0] S_EMIT = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;
   localparam logic [IW-1:0] W_LAST = IW'(OUT_SIZE - 1);
   localparam logic [SH-1:0] P_LAST = SH'(K * K - 1);

   logic [1:0]           state_q, state_d;
   logic [NB-1:0]        img_q, img_d;
   logic                 mode_q, mode_d;
   logic [IW-1:0]        wr_q, wr_d, wc_q, wc_d;
   logic [SH-1:0]        cnt_q, cnt_d;
   logic signed [AW-1:0] acc_q, acc_d;
   logic [DATA_W-1:0]    pixel_q, pixel_d;
   logic                 out_valid_q, out_valid_d;
   logic [IW-1:0]        out_row_q, out_row_d, out_col_q, out_col_d;
   logic                 finish_q, finish_d;
   logic                 busy_q, busy_d;
   int                   pix_idx;
   logic [DATA_W-1:0]    cur;
   logic signed [AW-1:0] cur_ext, acc_sum, acc_max, acc_nxt;
   logic [DATA_W-1:0]    res;
   logic                 last_win;

   // Current window pixel, running sum/max including it, and the pooled result it would give
   always_comb begin
      pix_idx  = (int'(wr_q) * K + int'(cnt_q[SH-1:KW])) * IMG_SIZE + int'(wc_q) * K + int'(cnt_q[KW-1:0]);
      cur      = img_q[pix_idx*DATA_W +: DATA_W];
      cur_ext  = AW'($signed(cur));
      acc_sum  = ((cnt_q == '0) ? AW'(0) : acc_q) + cur_ext;
      acc_max  = (cnt_q == '0 || $signed(cur) > $signed(acc_q[DATA_W-1:0])) ? cur_ext : acc_q;
      acc_nxt  = mode_q ? acc_max : acc_sum;
      res      = mode_q ? acc_nxt[DATA_W-1:0] : DATA_W'(acc_nxt >>> SH);
      last_win = (wr_q == W_LAST) && (wc_q == W_LAST);
   end

   // Next-state logic: IDLE latches the map, ACC folds one pixel per cycle, EMIT steps the window
   always_comb begin
      state_d     = state_q;
      img_d       = img_q;
      mode_d      = mode_q;
      wr_d        = wr_q;
      wc_d        = wc_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      pixel_d     = pixel_q;
      out_row_d   = out_row_q;
      out_col_d   = out_col_q;
      busy_d      = busy_q;
      out_valid_d = 1'b0;
      finish_d    = 1'b0;
      case (state_q)
         S_IDLE: if (start) begin
            img_d   = image_in;
            mode_d  = mode;
            wr_d    = '0;
            wc_d    = '0;
            cnt_d   = '0;
            acc_d   = '0;
            busy_d  = 1'b1;
            state_d = S_ACC;
         end
         S_ACC: begin
            acc_d = acc_nxt;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == P_LAST) begin
               pixel_d     = res;
               out_row_d   = wr_q;
               out_col_d   = wc_q;
               out_valid_d = 1'b1;
               state_d     = S_EMIT;
            end
         end
         S_EMIT: begin
            wc_d     = (wc_q == W_LAST) ? '0 : wc_q + 1'b1;
            wr_d     = (wc_q == W_LAST) ? wr_q + 1'b1 : wr_q;
            state_d  = last_win ? S_DONE : S_ACC;
            finish_d = last_win;
            busy_d   = !last_win;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         img_q       <= '0;
         mode_q      <= 1'b0;
         wr_q        <= '0;
         wc_q        <= '0;
         cnt_q       <= '0;
         acc_q       <= '0;
         pixel_q     <= '0;
         out_valid_q <= 1'b0;
         out_row_q   <= '0;
         out_col_q   <= '0;
         finish_q    <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         img_q       <= img_d;
         mode_q      <= mode_d;
         wr_q        <= wr_d;
         wc_q        <= wc_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         pixel_q     <= pixel_d;
         out_valid_q <= out_valid_d;
         out_row_q   <= out_row_d;
         out_col_q   <= out_col_d;
         finish_q    <= finish_d;
         busy_q      <= busy_d;
      end
   end

   assign busy      = busy_q;
   assign pixel_out = pixel_q;
   assign out_valid = out_valid_q;
   assign out_row   = out_row_q;
   assign out_col   = out_col_q;
   assign finish    = finish_q;
endmodule

// File: tb/tb_pooling_engine.sv
// tb_pooling_engine: scoreboard bench for pooling_engine (5x5/K=2 and 8x8/K=4 instances)
module tb_pooling_engine;
   typedef struct packed {
      logic [15:0] pix;
      logic [31:0] row;
      logic [31:0] col;
      logic [31:0] cyc;
   } ev_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start_a = 1'b0, mode_a = 1'b0, start_b = 1'b0, mode_b = 1'b0;
   logic [399:0] img_a = '0;
   logic [1023:0] img_b = '0;
   logic busy_a, val_a, fin_a, busy_b, val_b, fin_b;
   logic [15:0] pix_a, pix_b;
   logic [0:0] row_a, col_a, row_b, col_b;
   ev_t exp_q[$], obs_q[$];
   int fin_q[$], fexp_q[$];
   logic [20:0] snap;
   int n_checks = 0, n_fail = 0;

   always #5 clk = ~clk;

   pooling_engine dut_a (.clk(clk), .rst_n(rst_n), .start(start_a), .mode(mode_a), .image_in(img_a),
      .busy(busy_a), .pixel_out(pix_a), .out_valid(val_a), .out_row(row_a), .out_col(col_a), .finish(fin_a));
   pooling_engine #(.DATA_W(16), .IMG_SIZE(8), .K(4)) dut_b (.clk(clk), .rst_n(rst_n), .start(start_b),
      .mode(mode_b), .image_in(img_b), .busy(busy_b), .pixel_out(pix_b), .out_valid(val_b), .out_row(row_b),
      .out_col(col_b), .finish(fin_b));

   function automatic logic [1023:0] ramp(input int base, input int dir);
      logic [1023:0] m = '0;
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 5; c++) m[(r*5+c)*16 +: 16] = 16'(base + dir * (r*5+c));
      return m;
   endfunction

   function automatic logic [15:0] model(input logic [1023:0] img, input logic md, input int wr, input int wc);
      int s, m, v, q;
      s = 0;
      m = 0;
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 2; j++) begin
            v = int'($signed(img[((wr*2+i)*5 + wc*2+j)*16 +: 16]));
            s += v;
            if ((i == 0 && j == 0) || v > m) m = v;
         end
      q = s / 4;
      if (s < 0 && q * 4 != s) q -= 1;
      return md ? 16'(m) : 16'(q);
   endfunction

   function automatic void push_run(input logic [1023:0] img, input logic md, input int t0);
      for (int n = 0; n < 4; n++) exp_q.push_back('{model(img, md, n/2, n%2), n/2, n%2, t0 + 5*(n+1)});
      fexp_q.push_back(t0 + 21);
   endfunction

   // Drives one run and records every out_valid/finish with its cycle (start edge = cycle 0)
   task automatic collect(input bit b, input logic [1023:0] img, input logic md, input int ncyc,
                          input logic [63:0] smask, input logic [1023:0] img2, input logic md2, input int rst_cyc);
      logic [1023:0] junk;
      obs_q.delete();
      fin_q.delete();
      @(negedge clk);
      if (b) begin img_b = img; mode_b = md; start_b = 1'b1; end
      else begin img_a = img[399:0]; mode_a = md; start_a = 1'b1; end
      for (int c = 1; c <= ncyc; c++) begin
         @(negedge clk);
         if (b ? val_b : val_a)
            obs_q.push_back('{b ? pix_b : pix_a, 32'(b ? row_b : row_a), 32'(b ? col_b : col_a), 32'(c)});
         if (b ? fin_b : fin_a) fin_q.push_back(c);
         if (c == rst_cyc + 1) snap = {busy_a, val_a, fin_a, pix_a, row_a, col_a};
         rst_n = (c != rst_cyc);
         for (int w = 0; w < 32; w++) junk[w*32 +: 32] = $urandom;
         start_a = 1'b0;
         start_b = 1'b0;
         img_a = junk[399:0];
         img_b = junk;
         mode_a = junk[0];
         mode_b = junk[1];
         if (c < 64 && smask[c]) begin
            img_a = img2[399:0];
            mode_a = md2;
            start_a = 1'b1;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_checks += 3;
      if ({busy_a, val_a, fin_a} !== 3'b000) begin
         n_fail++; $display("FAIL reset_flags_a: got %b want 000", {busy_a, val_a, fin_a});
      end
      if ({pix_a, row_a, col_a} !== 18'd0) begin
         n_fail++; $display("FAIL reset_data_a: got %h want 0", {pix_a, row_a, col_a});
      end
      if ({busy_b, val_b, fin_b, pix_b, row_b, col_b} !== 21'd0) begin
         n_fail++; $display("FAIL reset_b: got %h want 0", {busy_b, val_b, fin_b, pix_b, row_b, col_b});
      end
      rst_n = 1'b1;
   endtask

   task automatic test_avg(input string tag);
      exp_q = '{'{16'd3, 0, 0, 5}, '{16'd5, 0, 1, 10}, '{16'd13, 1, 0, 15}, '{16'd15, 1, 1, 20}};
      collect(0, ramp(0, 1), 1'b0, 24, 64'd0, '0, 1'b0, -1);
      n_checks += 2;
      if (obs_q.size() != 4) begin n_fail++; $display("FAIL %s count: got %0d want 4", tag, obs_q.size()); end
      if (fin_q.size() != 1 || fin_q[0] != 21) begin
         n_fail++; $display("FAIL %s finish: got %p want '{21}", tag, fin_q);
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         ev_t e = exp_q.pop_front(), o = obs_q.pop_front();
         n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL %s out: got %h want %h", tag, o, e); end
      end
   endtask

   task automatic test_max();
      exp_q = '{'{16'd6, 0, 0, 5}, '{16'd8, 0, 1, 10}, '{16'd16, 1, 0, 15}, '{16'd18, 1, 1, 20}};
      collect(0, ramp(0, 1), 1'b1, 24, 64'd0, '0, 1'b0, -1);
      n_checks += 2;
      if (obs_q.size() != 4) begin n_fail++; $display("FAIL max count: got %0d want 4", obs_q.size()); end
      if (fin_q.size() != 1 || fin_q[0] != 21) begin n_fail++; $display("FAIL max finish: got %p want '{21}", fin_q); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         ev_t e = exp_q.pop_front(), o = obs_q.pop_front();
         n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL max out: got %h want %h", o, e); end
      end
   endtask

   task automatic test_neg_round();
      logic [1023:0] m = '0;
      for (int p = 0; p < 25; p++) m[p*16 +: 16] = 16'h8000;
      m[0*16 +: 16] = 16'hFFFF;
      m[1*16 +: 16] = 16'hFFFE;
      m[5*16 +: 16] = 16'hFFFE;
      m[6*16 +: 16] = 16'hFFFE;
      exp_q = '{'{16'hFFFE, 0, 0, 5}, '{16'h8000, 0, 1, 10}, '{16'h8000, 1, 0, 15}, '{16'h8000, 1, 1, 20}};
      collect(0, m, 1'b0, 24, 64'd0, '0, 1'b0, -1);
      n_checks++;
      if (obs_q.size() != 4) begin n_fail++; $display("FAIL neg count: got %0d want 4", obs_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         ev_t e = exp_q.pop_front(), o = obs_q.pop_front();
         n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL neg out: got %h want %h", o, e); end
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] sm = '0;
      logic [1023:0] img2 = ramp(100, -1);
      sm[7] = 1'b1;
      sm[21] = 1'b1;
      sm[23] = 1'b1;
      exp_q.delete();
      fexp_q.delete();
      push_run(ramp(0, 1), 1'b0, 0);
      push_run(img2, 1'b1, 23);
      collect(0, ramp(0, 1), 1'b0, 46, sm, img2, 1'b1, -1);
      n_checks += 2;
      if (obs_q.size() != 8) begin n_fail++; $display("FAIL b2b count: got %0d want 8", obs_q.size()); end
      if (fin_q != fexp_q) begin n_fail++; $display("FAIL b2b finish: got %p want %p", fin_q, fexp_q); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         ev_t e = exp_q.pop_front(), o = obs_q.pop_front();
         n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL b2b out: got %h want %h", o, e); end
      end
   endtask

   task automatic test_reset_mid();
      exp_q = '{'{16'd3, 0, 0, 5}, '{16'd5, 0, 1, 10}};
      snap = '1;
      collect(0, ramp(0, 1), 1'b0, 26, 64'd0, '0, 1'b0, 12);
      n_checks += 3;
      if (obs_q.size() != 2) begin n_fail++; $display("FAIL rstmid count: got %0d want 2", obs_q.size()); end
      if (fin_q.size() != 0) begin n_fail++; $display("FAIL rstmid finish: got %p want none", fin_q); end
      if (snap !== 21'd0) begin n_fail++; $display("FAIL rstmid outputs: got %h want 0", snap); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         ev_t e = exp_q.pop_front(), o = obs_q.pop_front();
         n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL rstmid out: got %h want %h", o, e); end
      end
   endtask

   task automatic test_random();
      logic [1023:0] m = '0;
      for (int t = 0; t < 4; t++) begin
         for (int p = 0; p < 25; p++) m[p*16 +: 16] = 16'($urandom);
         exp_q.delete();
         fexp_q.delete();
         push_run(m, t[0], 0);
         collect(0, m, t[0], 23, 64'd0, '0, 1'b0, -1);
         n_checks++;
         if (fin_q != fexp_q) begin n_fail++; $display("FAIL rand finish: got %p want %p", fin_q, fexp_q); end
         while (exp_q.size() > 0) begin
            ev_t e = exp_q.pop_front(), o = '0;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL rand out mode %0d: got %h want %h", t[0], o, e); end
         end
      end
   endtask

   task automatic test_k4();
      logic [1023:0] m = '0;
      for (int p = 0; p < 64; p++) m[p*16 +: 16] = 16'd7;
      m[(4*8+4)*16 +: 16] = 16'd100;
      for (int md = 0; md < 2; md++) begin
         exp_q = '{'{16'd7, 0, 0, 17}, '{16'd7, 0, 1, 34}, '{16'd7, 1, 0, 51}, '{md ? 16'd100 : 16'd12, 1, 1, 68}};
         collect(1, m, md[0], 72, 64'd0, '0, 1'b0, -1);
         n_checks += 2;
         if (obs_q.size() != 4) begin n_fail++; $display("FAIL k4 count: got %0d want 4", obs_q.size()); end
         if (fin_q.size() != 1 || fin_q[0] != 69) begin n_fail++; $display("FAIL k4 finish: got %p want '{69}", fin_q); end
         while (exp_q.size() > 0 && obs_q.size() > 0) begin
            ev_t e = exp_q.pop_front(), o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL k4 out mode %0d: got %h want %h", md, o, e); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_avg("avg");
      test_max();
      test_neg_round();
      test_back_to_back();
      test_reset_mid();
      test_avg("avg_after_reset");
      test_random();
      test_k4();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
